ysyx_22040386_wb_arbiter: RTL and testbench
===========================================

# ysyx_22040386_wb_arbiter

Writeback-port arbiter between the in-order pipeline WB stage and the multi-cycle multiply/divide unit (MDU); both share the single register-file write port. Buffers MDU results in a small FIFO, grants one writer per cycle, stalls WB when the MDU wins, and registers the selected write and commit info toward the register file and difftest. Exports a pending-destination mask for the ID-stage scoreboard.

## Interface
- STARVE_LIMIT, 4: consecutive pipeline wins tolerated while the MDU FIFO is non-empty (1..15).
- DEPTH, 2: MDU result FIFO entries; power of two, ≥2.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- i_WB_valid  in  1  WB stage holds an instruction
- i_WB_RegWrite  in  1  instruction writes rd
- i_WB_reg_wr_addr  in  5  rd
- i_WB_reg_wr_data  in  64  result
- i_WB_pc  in  64  instruction PC
- o_WB_stall  out  1  WB denied this cycle; hold i_WB_* stable
- i_mdu_valid  in  1  MDU result offered
- o_mdu_ready  out  1  FIFO can accept
- i_mdu_rd  in  5  MDU destination
- i_mdu_data  in  64  MDU result
- i_mdu_pc  in  64  MDU instruction PC
- o_rf_wen  out  1  register-file write enable
- o_rf_waddr  out  5  write address
- o_rf_wdata  out  64  write data
- o_commit_valid  out  1  one instruction retired
- o_commit_pc  out  64  retired PC
- o_busy_mask  out  32  bit r set: MDU write to xr still pending

## Operation
- Requesters: pipe_req = i_WB_valid; mdu_req = FIFO non-empty (head entry).
- Only one requesting: it wins. Both: pipeline wins, unless starvation override is active (see Configuration); then the MDU wins and o_WB_stall = 1.
- o_WB_stall = pipe_req && MDU granted; combinational, same cycle.
- A pipeline instruction with RegWrite = 0 still takes the slot and commits.
- Push on i_mdu_valid && o_mdu_ready; pop when the MDU is granted. o_mdu_ready = !full, derived from the registered count; a same-cycle pop does not raise ready.
- Simultaneous push and pop: count unchanged, pointers both advance mod DEPTH.
- Output register loads on every grant: o_commit_valid = 1, o_commit_pc = winner PC, o_rf_waddr/o_rf_wdata = winner fields, o_rf_wen = (pipe: RegWrite; MDU: 1) && rd != 0. With no grant: o_rf_wen = 0, o_commit_valid = 0; addr, data and PC hold.
- o_busy_mask = OR of decoded rd over valid FIFO entries, plus rd of the output register when it holds an MDU write; bit 0 always 0.

## Timing
- Grant and pop in cycle N; o_rf_* and o_commit_* valid in cycle N+1 (latency 1).
- An MDU entry pushed at the edge ending cycle N is grantable in cycle N+1 at the earliest. No bypass.
- Reset values: o_rf_wen 0, o_rf_waddr 0, o_rf_wdata 0, o_commit_valid 0, o_commit_pc 0, o_busy_mask 0, o_mdu_ready 1, o_WB_stall 0 (no requesters). FIFO empty, starvation counter 0.
- rst_n asserted mid-operation: buffered MDU results are discarded immediately, with no partial write.

## Configuration
- YSYX_22040386_WB_STARVE_EN defined: a 4-bit starve_cnt increments, saturating at STARVE_LIMIT, each cycle both request and the pipeline wins. It clears when the MDU wins or the FIFO is empty. When starve_cnt == STARVE_LIMIT and both request, the MDU wins.
- Undefined: no counter; strict pipeline priority. The MDU is served only in cycles with i_WB_valid = 0.

## Test plan
- Pipe only: i_WB_valid=1, RegWrite=1, rd=5, data=0x1234, pc=0x80000000 -> next cycle o_rf_wen=1, waddr=5, wdata=0x1234, commit_pc=0x80000000, o_WB_stall=0.
- x0 write: pipe rd=0, RegWrite=1 -> o_rf_wen=0, o_commit_valid=1.
- MDU, pipe idle: push rd=7, data=0xABCD in cycle 0 -> o_busy_mask[7]=1 in cycles 1–2; write visible in cycle 2; mask bit clear in cycle 3.
- FIFO full: pipe valid every cycle, STARVE off, 3 MDU offers -> 2 accepted, o_mdu_ready=0 from cycle 2; after i_WB_valid drops, entries drain in push order.
- Starvation (EN, LIMIT=4): one FIFO entry, pipe valid every cycle -> pipe granted 4 cycles; in the 5th, o_WB_stall=1 and the MDU write appears the next cycle; the pipe then resumes.
- Reset mid-op: 2 entries buffered, pulse rst_n low between edges -> outputs immediately at reset values, mask 0, no later MDU write.

Source files
------------

// File: rtl/ysyx_22040386_wb_arbiter.sv
// Register-file write-port arbiter between the WB stage and the MDU result FIFO.
// Optional MDU anti-starvation counter is enabled by defining YSYX_22040386_WB_STARVE_EN.
module ysyx_22040386_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_WB_valid,
    input  logic        i_WB_RegWrite,
    input  logic [4:0]  i_WB_reg_wr_addr,
    input  logic [63:0] i_WB_reg_wr_data,
    input  logic [63:0] i_WB_pc,
    output logic        o_WB_stall,
    input  logic        i_mdu_valid,
    output logic        o_mdu_ready,
    input  logic [4:0]  i_mdu_rd,
    input  logic [63:0] i_mdu_data,
    input  logic [63:0] i_mdu_pc,
    output logic        o_rf_wen,
    output logic [4:0]  o_rf_waddr,
    output logic [63:0] o_rf_wdata,
    output logic        o_commit_valid,
    output logic [63:0] o_commit_pc,
    output logic [31:0] o_busy_mask
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
    } mdu_entry_t;

    mdu_entry_t       fifo_mem [DEPTH];
    logic [DEPTH-1:0] fifo_vld, vld_nxt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    mdu_entry_t       head;
    logic             push, pop, pipe_req, mdu_req, mdu_grant, pipe_grant, starve_hit;
    logic             out_mdu_pend;

    assign head        = fifo_mem[rd_ptr];
    assign pipe_req    = i_WB_valid;
    assign mdu_req     = (count != '0);
    assign o_mdu_ready = (count != FULL_CNT);
    assign push        = i_mdu_valid && o_mdu_ready;
    assign mdu_grant   = mdu_req && (!pipe_req || starve_hit);
    assign pipe_grant  = pipe_req && !mdu_grant;
    assign pop         = mdu_grant;
    assign o_WB_stall  = pipe_req && mdu_grant;

`ifdef YSYX_22040386_WB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign starve_hit = (starve_cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!mdu_req || mdu_grant) begin
            starve_cnt <= '0;
        end else if (pipe_grant && !starve_hit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        vld_nxt = fifo_vld;
        if (pop)  vld_nxt[rd_ptr] = 1'b0;
        if (push) vld_nxt[wr_ptr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_vld <= vld_nxt;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; fifo_vld/count gate every use, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{rd: i_mdu_rd, data: i_mdu_data, pc: i_mdu_pc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rf_wen       <= 1'b0;
            o_rf_waddr     <= '0;
            o_rf_wdata     <= '0;
            o_commit_valid <= 1'b0;
            o_commit_pc    <= '0;
            out_mdu_pend   <= 1'b0;
        end else begin
            o_rf_wen       <= 1'b0;
            o_commit_valid <= 1'b0;
            out_mdu_pend   <= 1'b0;
            if (mdu_grant) begin
                o_rf_wen       <= (head.rd != 5'd0);
                o_rf_waddr     <= head.rd;
                o_rf_wdata     <= head.data;
                o_commit_valid <= 1'b1;
                o_commit_pc    <= head.pc;
                out_mdu_pend   <= (head.rd != 5'd0);
            end else if (pipe_grant) begin
                o_rf_wen       <= i_WB_RegWrite && (i_WB_reg_wr_addr != 5'd0);
                o_rf_waddr     <= i_WB_reg_wr_addr;
                o_rf_wdata     <= i_WB_reg_wr_data;
                o_commit_valid <= 1'b1;
                o_commit_pc    <= i_WB_pc;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        o_busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i]) o_busy_mask[fifo_mem[i].rd] = 1'b1;
        end
        if (out_mdu_pend) o_busy_mask[o_rf_waddr] = 1'b1;
        o_busy_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_ysyx_22040386_wb_arbiter.sv
// Scoreboard bench for ysyx_22040386_wb_arbiter; follows YSYX_22040386_WB_STARVE_EN if defined.
module tb_ysyx_22040386_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef YSYX_22040386_WB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_WB_valid, i_WB_RegWrite, i_mdu_valid;
    logic [4:0]  i_WB_reg_wr_addr, i_mdu_rd;
    logic [63:0] i_WB_reg_wr_data, i_WB_pc, i_mdu_data, i_mdu_pc;
    logic        o_WB_stall, o_mdu_ready, o_rf_wen, o_commit_valid;
    logic [4:0]  o_rf_waddr;
    logic [63:0] o_rf_wdata, o_commit_pc;
    logic [31:0] o_busy_mask;

    ysyx_22040386_wb_arbiter #(.STARVE_LIMIT(LIMIT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_WB_valid(i_WB_valid), .i_WB_RegWrite(i_WB_RegWrite),
        .i_WB_reg_wr_addr(i_WB_reg_wr_addr), .i_WB_reg_wr_data(i_WB_reg_wr_data),
        .i_WB_pc(i_WB_pc), .o_WB_stall(o_WB_stall),
        .i_mdu_valid(i_mdu_valid), .o_mdu_ready(o_mdu_ready),
        .i_mdu_rd(i_mdu_rd), .i_mdu_data(i_mdu_data), .i_mdu_pc(i_mdu_pc),
        .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_commit_valid(o_commit_valid), .o_commit_pc(o_commit_pc),
        .o_busy_mask(o_busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
    } ent_t;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic        cv;
        logic [63:0] pc;
    } out_t;

    ent_t       mq[$];
    out_t       exp_q[$];
    out_t       m_last;
    int         m_starve;
    logic       m_pend;
    logic [4:0] m_pend_rd;
    logic       obs_stall;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_last    = '{wen: 1'b0, waddr: 5'd0, wdata: 64'd0, cv: 1'b0, pc: 64'd0};
        m_starve  = 0;
        m_pend    = 1'b0;
        m_pend_rd = 5'd0;
        obs_stall = 1'b0;
    endtask

    // One cycle: drive, compare combinational outputs, predict the registered result,
    // then pop and compare it after the edge.
    task automatic step(input logic pv, input logic rw, input logic [4:0] rd,
                        input logic [63:0] data, input logic [63:0] pc,
                        input logic mv, input logic [4:0] mrd,
                        input logic [63:0] mdata, input logic [63:0] mpc);
        logic        mreq, hit, mg, pg, rdy;
        logic [31:0] emask;
        out_t        o;
        ent_t        e;
        i_WB_valid = pv; i_WB_RegWrite = rw; i_WB_reg_wr_addr = rd;
        i_WB_reg_wr_data = data; i_WB_pc = pc;
        i_mdu_valid = mv; i_mdu_rd = mrd; i_mdu_data = mdata; i_mdu_pc = mpc;
        #1;
        mreq = (mq.size() != 0);
        hit  = STARVE_ON && (m_starve == LIMIT);
        mg   = mreq && (!pv || hit);
        pg   = pv && !mg;
        rdy  = (mq.size() < DEPTH);
        emask = '0;
        foreach (mq[i]) emask[mq[i].rd] = 1'b1;
        if (m_pend) emask[m_pend_rd] = 1'b1;
        emask[0] = 1'b0;
        obs_stall = o_WB_stall;
        n_checks++;
        if (o_WB_stall !== (pv && mg)) $display("FAIL stall: got %b expected %b", o_WB_stall, pv && mg);
        else n_pass++;
        n_checks++;
        if (o_mdu_ready !== rdy) $display("FAIL mdu_ready: got %b expected %b", o_mdu_ready, rdy);
        else n_pass++;
        n_checks++;
        if (o_busy_mask !== emask) $display("FAIL busy_mask: got %h expected %h", o_busy_mask, emask);
        else n_pass++;

        o = m_last;
        o.wen = 1'b0;
        o.cv  = 1'b0;
        if (mg) begin
            e = mq.pop_front();
            o = '{wen: (e.rd != 5'd0), waddr: e.rd, wdata: e.data, cv: 1'b1, pc: e.pc};
        end else if (pg) begin
            o = '{wen: rw && (rd != 5'd0), waddr: rd, wdata: data, cv: 1'b1, pc: pc};
        end
        m_pend    = mg && o.wen;
        m_pend_rd = o.waddr;
        if (mv && rdy) mq.push_back('{rd: mrd, data: mdata, pc: mpc});
        if (!mreq || mg) m_starve = 0;
        else if (pg && m_starve < LIMIT) m_starve++;
        m_last = o;
        exp_q.push_back(o);

        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        n_checks++;
        if ({o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_valid, o_commit_pc} !==
            {o.wen, o.waddr, o.wdata, o.cv, o.pc})
            $display("FAIL rf_out: got wen=%b addr=%0d data=%h cv=%b pc=%h expected wen=%b addr=%0d data=%h cv=%b pc=%h",
                     o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_valid, o_commit_pc,
                     o.wen, o.waddr, o.wdata, o.cv, o.pc);
        else n_pass++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 64'd0, 64'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_WB_valid = 1'b0; i_WB_RegWrite = 1'b0; i_WB_reg_wr_addr = '0;
        i_WB_reg_wr_data = '0; i_WB_pc = '0;
        i_mdu_valid = 1'b0; i_mdu_rd = '0; i_mdu_data = '0; i_mdu_pc = '0;
        model_reset();
        #1;
        n_checks++;
        if ({o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_valid, o_commit_pc} !== 135'd0)
            $display("FAIL reset_out: got wen=%b addr=%0d data=%h cv=%b pc=%h expected all zero",
                     o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_valid, o_commit_pc);
        else n_pass++;
        n_checks++;
        if (o_busy_mask !== 32'd0) $display("FAIL reset_mask: got %h expected 0", o_busy_mask);
        else n_pass++;
        n_checks++;
        if ({o_mdu_ready, o_WB_stall} !== 2'b10)
            $display("FAIL reset_ready_stall: got %b%b expected 10", o_mdu_ready, o_WB_stall);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_pipe_only();
        step(1'b1, 1'b1, 5'd5, 64'h1234, 64'h8000_0000, 1'b0, 5'd0, 64'd0, 64'd0);
        n_checks++;
        if ({o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_pc, obs_stall} !==
            {1'b1, 5'd5, 64'h1234, 64'h8000_0000, 1'b0})
            $display("FAIL pipe_only: got wen=%b addr=%0d data=%h pc=%h stall=%b expected 1 5 1234 80000000 0",
                     o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_pc, obs_stall);
        else n_pass++;
    endtask

    task automatic test_x0_and_nowrite();
        step(1'b1, 1'b1, 5'd0, 64'h55, 64'h8000_0004, 1'b0, 5'd0, 64'd0, 64'd0);
        n_checks++;
        if ({o_rf_wen, o_commit_valid} !== 2'b01)
            $display("FAIL x0_write: got wen=%b cv=%b expected wen=0 cv=1", o_rf_wen, o_commit_valid);
        else n_pass++;
        step(1'b1, 1'b0, 5'd8, 64'h66, 64'h8000_0008, 1'b0, 5'd0, 64'd0, 64'd0);
        n_checks++;
        if ({o_rf_wen, o_commit_valid, o_commit_pc} !== {2'b01, 64'h8000_0008})
            $display("FAIL no_regwrite: got wen=%b cv=%b pc=%h expected 0 1 80000008",
                     o_rf_wen, o_commit_valid, o_commit_pc);
        else n_pass++;
    endtask

    task automatic test_mdu_idle();
        step(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 5'd7, 64'hABCD, 64'h4000);
        n_checks++;
        if ({o_busy_mask[7], o_rf_wen} !== 2'b10)
            $display("FAIL mdu_c1: got mask7=%b wen=%b expected 1 0", o_busy_mask[7], o_rf_wen);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({o_busy_mask[7], o_rf_wen, o_rf_waddr, o_rf_wdata} !== {2'b11, 5'd7, 64'hABCD})
            $display("FAIL mdu_c2: got mask7=%b wen=%b addr=%0d data=%h expected 1 1 7 abcd",
                     o_busy_mask[7], o_rf_wen, o_rf_waddr, o_rf_wdata);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({o_busy_mask[7], o_rf_wen} !== 2'b00)
            $display("FAIL mdu_c3: got mask7=%b wen=%b expected 0 0", o_busy_mask[7], o_rf_wen);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [4:0] rds [3] = '{5'd3, 5'd4, 5'd6};
        logic       rdy_exp [3] = '{1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 5'd2, 64'(c), 64'h5000 + 64'(4 * c), 1'b1, rds[c], 64'h100 + 64'(c), 64'h6000 + 64'(c));
            n_checks++;
            if (o_mdu_ready !== rdy_exp[c])
                $display("FAIL full_ready_c%0d: got %b expected %b", c + 1, o_mdu_ready, rdy_exp[c]);
            else n_pass++;
        end
        idle(1);
        n_checks++;
        if ({o_rf_waddr, o_rf_wdata, o_commit_pc} !== {5'd3, 64'h100, 64'h6000})
            $display("FAIL drain_first: got addr=%0d data=%h pc=%h expected 3 100 6000",
                     o_rf_waddr, o_rf_wdata, o_commit_pc);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({o_rf_waddr, o_rf_wdata, o_commit_pc} !== {5'd4, 64'h101, 64'h6001})
            $display("FAIL drain_second: got addr=%0d data=%h pc=%h expected 4 101 6001",
                     o_rf_waddr, o_rf_wdata, o_commit_pc);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({o_rf_wen, o_mdu_ready} !== 2'b01)
            $display("FAIL drain_done: got wen=%b ready=%b expected 0 1", o_rf_wen, o_mdu_ready);
        else n_pass++;
    endtask

`ifdef YSYX_22040386_WB_STARVE_EN
    task automatic test_starvation();
        int k = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b1, 5'd1, 64'(c), 64'h2000 + 64'(4 * k), c == 0, 5'd9, 64'h99, 64'h3000);
            n_checks++;
            if (obs_stall !== (c == 5)) $display("FAIL starve_stall_c%0d: got %b expected %b", c, obs_stall, c == 5);
            else n_pass++;
            if (c != 5) k++;
            if (c == 5) begin
                n_checks++;
                if ({o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_pc} !== {1'b1, 5'd9, 64'h99, 64'h3000})
                    $display("FAIL starve_mdu_write: got wen=%b addr=%0d data=%h pc=%h expected 1 9 99 3000",
                             o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_pc);
                else n_pass++;
            end
            if (c == 6) begin
                n_checks++;
                if (o_commit_pc !== 64'h2014) $display("FAIL starve_resume: got pc=%h expected 2014", o_commit_pc);
                else n_pass++;
            end
        end
        idle(1);
    endtask
`else
    task automatic test_starvation();
        logic any_stall = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b1, 5'd1, 64'(c), 64'h2000 + 64'(4 * c), c == 0, 5'd9, 64'h99, 64'h3000);
            any_stall |= obs_stall;
        end
        n_checks++;
        if ({any_stall, o_busy_mask[9]} !== 2'b01)
            $display("FAIL strict_priority: got stall_seen=%b mask9=%b expected 0 1", any_stall, o_busy_mask[9]);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({o_rf_wen, o_rf_waddr, o_rf_wdata} !== {1'b1, 5'd9, 64'h99})
            $display("FAIL strict_drain: got wen=%b addr=%0d data=%h expected 1 9 99", o_rf_wen, o_rf_waddr, o_rf_wdata);
        else n_pass++;
        idle(1);
    endtask
`endif

    task automatic test_back_to_back();
        logic        pv = 1'b0, rw = 1'b0;
        logic [4:0]  rd = '0;
        logic [63:0] d = '0, pc = '0;
        obs_stall = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (!obs_stall) begin
                pv = 1'($urandom_range(0, 1));
                rw = 1'($urandom_range(0, 1));
                rd = 5'($urandom_range(0, 31));
                d  = {$urandom, $urandom};
                pc = 64'h9000_0000 + 64'(4 * c);
            end
            step(pv, rw, rd, d, pc, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 64'hA000_0000 + 64'(4 * c));
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 5'd2, 64'h1, 64'h7000, 1'b1, 5'd10, 64'hA0, 64'h7100);
        step(1'b1, 1'b1, 5'd2, 64'h2, 64'h7004, 1'b1, 5'd11, 64'hB0, 64'h7104);
        n_checks++;
        if (o_busy_mask !== 32'h0000_0C00) $display("FAIL pre_reset_mask: got %h expected 00000c00", o_busy_mask);
        else n_pass++;
        i_WB_valid = 1'b0;
        i_mdu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_valid, o_commit_pc, o_busy_mask, o_mdu_ready, o_WB_stall} !==
            {135'd0, 32'd0, 2'b10})
            $display("FAIL mid_reset: got wen=%b addr=%0d data=%h cv=%b pc=%h mask=%h ready=%b stall=%b expected zeros ready=1",
                     o_rf_wen, o_rf_waddr, o_rf_wdata, o_commit_valid, o_commit_pc, o_busy_mask, o_mdu_ready, o_WB_stall);
        else n_pass++;
        model_reset();
        #1;
        rst_n = 1'b1;
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pipe_only();
        test_x0_and_nowrite();
        test_mdu_idle();
        test_fifo_full();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
